// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit signal bundle: ROM port, redirect input and decode-side valid/ready output.
// The fetch_fault signal exists only when FETCH_FAULT_EN is defined.
interface inst_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [31:0]           rom_data;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_pc;
  logic [31:0]           out_inst;
`ifdef FETCH_FAULT_EN
  logic                  fetch_fault;
`endif

  modport master (
    output rom_addr,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
`ifdef FETCH_FAULT_EN
    output fetch_fault,
`endif
    output out_inst
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
`ifdef FETCH_FAULT_EN
    input  fetch_fault,
`endif
    input  out_inst
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, async ROM capture, prefetch FIFO and redirect flush.
// Optional macro FETCH_FAULT_EN adds out-of-ROM fault tagging and fetch stop.
module inst_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_unit_if.master bus
);
  localparam int unsigned     PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned     CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     pc_mem_q   [FIFO_DEPTH];
  logic [31:0]     inst_mem_q [FIFO_DEPTH];
  logic            valid, push, pop, fetch_en;
  logic [31:0]     fetch_inst;

`ifdef FETCH_FAULT_EN
  localparam logic [31:0] NopInst = 32'h0000_0013;

  logic [FIFO_DEPTH-1:0] fault_mem_q;
  logic                  stall_q, stall_d;
  logic                  pc_fault;

  assign pc_fault   = pc_q[31:ADDR_WIDTH+2] != '0;
  assign fetch_en   = !stall_q;
  assign fetch_inst = pc_fault ? NopInst : bus.rom_data;
`else
  assign fetch_en   = 1'b1;
  assign fetch_inst = bus.rom_data;
`endif

  assign bus.rom_addr = pc_q[ADDR_WIDTH+1:2];
  assign valid        = count_q != '0;
  assign pop          = valid && bus.out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO keeps streaming.
  assign push         = !bus.redirect_valid && fetch_en && ((count_q < DepthCnt) || pop);

  always_comb begin
    bus.out_valid = valid;
    bus.out_pc    = '0;
    bus.out_inst  = '0;
    if (valid) begin
      bus.out_pc   = pc_mem_q[rd_ptr_q];
      bus.out_inst = inst_mem_q[rd_ptr_q];
    end
`ifdef FETCH_FAULT_EN
    bus.fetch_fault = valid && fault_mem_q[rd_ptr_q];
`endif
  end

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
`ifdef FETCH_FAULT_EN
    stall_d  = stall_q;
`endif
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_pc & ~32'h3;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
`ifdef FETCH_FAULT_EN
      stall_d  = 1'b0;
`endif
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef FETCH_FAULT_EN
        stall_d  = stall_q | pc_fault;
`endif
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
`ifdef FETCH_FAULT_EN
      stall_q  <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
`ifdef FETCH_FAULT_EN
      stall_q  <= stall_d;
`endif
    end
  end

  // Storage needs no reset: out_* are gated by valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      inst_mem_q[wr_ptr_q] <= fetch_inst;
`ifdef FETCH_FAULT_EN
      fault_mem_q[wr_ptr_q] <= pc_fault;
`endif
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: queue-based stream model against a synthetic ROM
// (word k = 32'hA000_0000 + k), directed phases plus randomized ready/redirect traffic.
module tb_inst_fetch_unit;
  localparam int unsigned AW       = 12;
  localparam logic [31:0] ResetPc  = 32'h0000_0000;
  localparam int unsigned Depth    = 4;
`ifdef FETCH_FAULT_EN
  localparam bit          FaultEn  = 1'b1;
`else
  localparam bit          FaultEn  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

  inst_fetch_unit #(
    .ADDR_WIDTH(AW),
    .RESET_PC  (ResetPc),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.rom_data = 32'hA000_0000 + 32'(bus.rom_addr);

  typedef struct {
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_stop;
  int unsigned n_vec;
  int unsigned n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_inst(input ent_t e);
    if (e.fault) return 32'h0000_0013;
    return 32'hA000_0000 + ((e.pc >> 2) % (32'd1 << AW));
  endfunction

  // Check outputs against the model, apply inputs for one cycle, then advance the model.
  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    bit   pop;
    bit   push;
    ent_t e;
    @(negedge clk);
    check_eq("rom_addr", 32'(bus.rom_addr), (m_pc >> 2) % (32'd1 << AW));
    check_eq("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("out_pc", bus.out_pc, mq[0].pc);
      check_eq("out_inst", bus.out_inst, exp_inst(mq[0]));
`ifdef FETCH_FAULT_EN
      check_eq("fetch_fault", 32'(bus.fetch_fault), 32'(mq[0].fault));
`endif
    end
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.out_ready      = rdy;
    @(posedge clk);
    pop = (mq.size() != 0) && rdy;
    if (r) begin
      mq.delete();
      m_pc   = ResetPc;
      m_stop = 1'b0;
    end else if (rv) begin
      mq.delete();
      m_pc   = rp & ~32'h3;
      m_stop = 1'b0;
    end else begin
      push = !m_stop && ((mq.size() < Depth) || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc    = m_pc;
        e.fault = FaultEn && ((m_pc >> (AW + 2)) != 0);
        mq.push_back(e);
        if (e.fault) m_stop = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    n_vec              = 0;
    n_err              = 0;
    m_pc               = ResetPc;
    m_stop             = 1'b0;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_pc", bus.out_pc, 32'd0);
    check_eq("rst_out_inst", bus.out_inst, 32'd0);
    check_eq("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
`ifdef FETCH_FAULT_EN
    check_eq("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
`endif
    step(1'b1, 1'b0, 32'd0, 1'b1);

    // Streaming with ready held high.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    // Backpressure until full, then drain.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect with a full FIFO and a pop in the same cycle.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

    // PC wrap past 32'hFFFF_FFFC.
    step(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Randomized ready with occasional redirects.
    step(1'b0, 1'b1, 32'h0000_0200, 1'b0);
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'($urandom_range(0, 15) == 0), $urandom & 32'h0000_3FFF,
           1'($urandom_range(0, 1)));
    end

    // Reset with three entries buffered.
    step(1'b0, 1'b1, 32'h0000_0080, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1);

`ifdef FETCH_FAULT_EN
    // Fetch beyond the ROM: one faulting NOP, then silence until redirect.
    step(1'b0, 1'b1, 32'h0000_4000, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_3FF8, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
`endif

    step(1'b0, 1'b0, 32'd0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
